// File: rtl/if_pkg.sv
// ============================================================================
// Module : if_pkg
// Brief  : Shared types and constants for the instruction fetch unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_pkg;

    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;
    // Widest supported PC; narrower PCs are zero-extended inside buffer entries.
    localparam int PC_W        = 64;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [1:0] i_lsb);
        return |i_lsb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// Module : fetch_buffer
// Brief  : Two-entry shift FIFO of {pc, instr} pairs with push/pop/flush.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buffer
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count,
    output logic         o_full,
    output logic         o_empty
);

    localparam logic [1:0] c_DEPTH = 2'(DEPTH);

    fetch_entry_t r_slot0;
    fetch_entry_t r_slot1;
    logic [1:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == 2'd0);
    assign o_full    = (r_count == c_DEPTH);
    assign w_do_pop  = i_pop & ~o_empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_slot0 <= i_entry;
                    end else begin
                        r_slot1 <= i_entry;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    // Popping the last entry leaves the head registers untouched.
                    if (r_count == 2'd2) begin
                        r_slot0 <= r_slot1;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_slot0 <= i_entry;
                    end else begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= i_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head  = r_slot0;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module : instr_fetch_unit
// Brief  : Fetch PC, imem request, redirect/fault handling and decode handshake.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import if_pkg::*;
#(
    parameter int          N        = 64,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [N-1:0]    imem_addr,
    input  logic [31:0]     imem_instr,
    input  logic            redirect_valid,
    input  logic [N-1:0]    redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [N-1:0]    if_pc,
    output logic [31:0]     if_instr,
    output logic            fetch_fault
);

    localparam logic [N-1:0] c_RESET_PC = RESET_PC[N-1:0] & ~N'(3);

    logic [N-1:0] r_fetch_pc;
    logic         r_fault;

    logic         w_pop;
    logic         w_fetch;
    logic         w_full;
    logic         w_empty;
    logic [1:0]   w_count;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    assign w_pop   = ~w_empty & if_ready;
    assign w_fetch = ~r_fault & ~redirect_valid & (~w_full | w_pop);

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.pc    = PC_W'(r_fetch_pc);
        w_push_entry.instr = imem_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= c_RESET_PC;
            r_fault    <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_fault    <= is_misaligned(redirect_pc[1:0]);
        end else if (w_fetch) begin
            r_fetch_pc <= r_fetch_pc + N'(INSTR_BYTES);
        end
    end

    // A redirect flushes the buffer, discarding even an entry being popped.
    fetch_buffer #(
        .DEPTH   (DEPTH)
    ) u_fetch_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_fetch),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    logic w_count_unused;
    assign w_count_unused = ^w_count;

    assign imem_addr   = r_fetch_pc;
    assign if_valid    = ~w_empty;
    assign if_pc       = w_head.pc[N-1:0];
    assign if_instr    = w_head.instr;
    assign fetch_fault = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module : tb_instr_fetch_unit
// Brief  : Randomized self-checking bench with a queue-based fetch model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [63:0] m_pc;
    logic        m_fault;

    instr_fetch_unit #(
        .N        (64),
        .RESET_PC (64'h0),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .fetch_fault    (fetch_fault)
    );

    // 4 KiB memory, aliased on higher address bits.
    assign imem_instr = mem[imem_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rv, input logic [63:0] rpc, input logic rdy);
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
    endtask

    // Advance the reference model by one clock using the inputs now applied.
    task automatic advance();
        ent_t e;
        if (redirect_valid) begin
            m_q.delete();
            m_pc    = redirect_pc;
            m_fault = (redirect_pc[1:0] != 2'b00);
        end else begin
            if (m_q.size() != 0 && if_ready) m_q.delete(0);
            if (!m_fault && m_q.size() < 2) begin
                e.pc    = m_pc;
                e.instr = mem[m_pc[11:2]];
                m_q.push_back(e);
                m_pc = m_pc + 64'd4;
            end
        end
        @(posedge clk);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc    = 64'h0;
        m_fault = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        if_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
        total++; if (if_pc !== 64'h0 || if_instr !== 32'h0) begin bad++; $display("FAIL reset_head got=%h/%h exp=0/0", if_pc, if_instr); end
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
        total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        model_reset();
        drive(1'b0, 64'h0, 1'b1);
        rst_n = 1'b1;
        advance();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            if (i == 0) begin
                total++; if (if_valid !== 1'b1 || if_pc !== 64'h0 || if_instr !== 32'h00000013) begin bad++; $display("FAIL stream_first got=%b/%h/%h exp=1/0/00000013", if_valid, if_pc, if_instr); end
            end
            if (i == 1) begin
                total++; if (if_pc !== 64'h4 || if_instr !== 32'h00100093) begin bad++; $display("FAIL stream_second got=%h/%h exp=4/00100093", if_pc, if_instr); end
            end
            total++; if (if_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL stream_valid got=%b exp=%b", if_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                total++; if (if_pc !== m_q[0].pc || if_instr !== m_q[0].instr) begin bad++; $display("FAIL stream_head got=%h/%h exp=%h/%h", if_pc, if_instr, m_q[0].pc, m_q[0].instr); end
            end
            total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL stream_addr got=%h exp=%h", imem_addr, m_pc); end
            advance();
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 64'h0, 1'b1);
        advance();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 64'h0, (i >= 5));
            if (i == 5) begin
                total++; if (imem_addr !== 64'h8 || if_pc !== 64'h0 || !if_valid) begin bad++; $display("FAIL bp_stall got=%h/%h/%b exp=8/0/1", imem_addr, if_pc, if_valid); end
            end
            if (i >= 5 && i <= 7) begin
                total++; if (if_valid !== 1'b1 || if_pc !== 64'(4 * (i - 5))) begin bad++; $display("FAIL bp_drain got=%b/%h exp=1/%h", if_valid, if_pc, 64'(4 * (i - 5))); end
            end
            total++; if (if_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL bp_valid got=%b exp=%b", if_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                total++; if (if_pc !== m_q[0].pc || if_instr !== m_q[0].instr) begin bad++; $display("FAIL bp_head got=%h/%h exp=%h/%h", if_pc, if_instr, m_q[0].pc, m_q[0].instr); end
            end
            total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL bp_addr got=%h exp=%h", imem_addr, m_pc); end
            advance();
        end
    endtask

    task automatic test_redirect_full();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'h0, 1'b0);
            advance();
        end
        drive(1'b1, 64'h100, 1'b1);
        total++; if (m_q.size() != 2 || if_valid !== 1'b1) begin bad++; $display("FAIL redir_prefull got=%b exp=1 model_count=%0d", if_valid, m_q.size()); end
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            if (i == 0) begin
                total++; if (if_valid !== 1'b0 || imem_addr !== 64'h100) begin bad++; $display("FAIL redir_flush got=%b/%h exp=0/100", if_valid, imem_addr); end
            end
            if (i >= 1) begin
                total++; if (if_pc !== 64'h100 + 64'(4 * (i - 1))) begin bad++; $display("FAIL redir_seq got=%h exp=%h", if_pc, 64'h100 + 64'(4 * (i - 1))); end
            end
            total++; if (if_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL redir_valid got=%b exp=%b", if_valid, m_q.size() != 0); end
            total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL redir_addr got=%h exp=%h", imem_addr, m_pc); end
            advance();
        end
    endtask

    task automatic test_fault();
        drive(1'b1, 64'h102, 1'b1);
        advance();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 64'h0, 1'($urandom_range(0, 1)));
            total++; if (fetch_fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 64'h102) begin bad++; $display("FAIL fault_hold got=%b/%b/%h exp=1/0/102", fetch_fault, if_valid, imem_addr); end
            advance();
        end
        drive(1'b1, 64'h200, 1'b1);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            total++; if (fetch_fault !== m_fault) begin bad++; $display("FAIL fault_clear got=%b exp=%b", fetch_fault, m_fault); end
            if (i == 1) begin
                total++; if (if_valid !== 1'b1 || if_pc !== 64'h200) begin bad++; $display("FAIL fault_resume got=%b/%h exp=1/200", if_valid, if_pc); end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            if (i == 1) begin
                total++; if (if_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%h exp=fffffffffffffffc", if_pc); end
            end
            if (i == 2) begin
                total++; if (if_pc !== 64'h0 || if_instr !== 32'h00000013) begin bad++; $display("FAIL wrap_zero got=%h/%h exp=0/00000013", if_pc, if_instr); end
            end
            total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL wrap_addr got=%h exp=%h", imem_addr, m_pc); end
            advance();
        end
    endtask

    task automatic test_random();
        logic        rv;
        logic [63:0] rpc;
        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 15) == 0);
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            drive(rv, rpc, 1'($urandom_range(0, 2) != 0));
            total++; if (if_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, if_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                total++; if (if_pc !== m_q[0].pc || if_instr !== m_q[0].instr) begin bad++; $display("FAIL rand_head cyc=%0d got=%h/%h exp=%h/%h", i, if_pc, if_instr, m_q[0].pc, m_q[0].instr); end
            end
            total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", i, imem_addr, m_pc); end
            total++; if (fetch_fault !== m_fault) begin bad++; $display("FAIL rand_fault cyc=%0d got=%b exp=%b", i, fetch_fault, m_fault); end
            advance();
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 64'h40, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'h0, 1'b0);
            advance();
        end
        @(negedge clk);
        #2;
        total++; if (if_valid !== 1'b1 || m_q.size() != 2) begin bad++; $display("FAIL arst_prefull got=%b exp=1 model_count=%0d", if_valid, m_q.size()); end
        rst_n = 1'b0;
        #1;
        total++; if (if_valid !== 1'b0 || fetch_fault !== 1'b0) begin bad++; $display("FAIL arst_clear got=%b/%b exp=0/0", if_valid, fetch_fault); end
        total++; if (imem_addr !== 64'h0 || if_pc !== 64'h0) begin bad++; $display("FAIL arst_regs got=%h/%h exp=0/0", imem_addr, if_pc); end
        model_reset();
        @(posedge clk);
        drive(1'b0, 64'h0, 1'b1);
        rst_n = 1'b1;
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            total++; if (if_valid !== 1'b1 || if_pc !== 64'(4 * i)) begin bad++; $display("FAIL arst_restart got=%b/%h exp=1/%h", if_valid, if_pc, 64'(4 * i)); end
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h00000013;
        mem[1] = 32'h00100093;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_fault();
        test_wrap();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
